tcp_pkt_serializer: RTL and testbench

Transmit-side counterpart of the header parsing path. Accepts one Ethernet/IPv4/TCP header set as the shared package structs, serializes it onto an 8-bit network-order byte stream, then forwards the TCP payload bytes from an input stream. Optionally computes the IPv4 header checksum. Sits between the alert/response generator and the MAC transmit FIFO.

---
 rtl/tcp_pkt_serializer_pkg.sv | 64 ++++++
 rtl/tcp_pkt_serializer_csum.sv | 33 +++
 rtl/tcp_pkt_serializer.sv | 186 ++++++++++++++++++
 tb/tb_tcp_pkt_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkt_serializer_pkg.sv
// Shared protocol package: Ethernet/IPv4/TCP header structs, header sizes,
// transmit serializer state encoding and an IPv4 checksum word helper.
package tcp_pkt_serializer_pkg;

  localparam int unsigned ETH_HDR_BYTES  = 14;
  localparam int unsigned IPV4_HDR_BYTES = 20;
  localparam int unsigned TCP_HDR_BYTES  = 20;
  localparam int unsigned TX_HDR_BYTES   = 54;
  localparam int unsigned IPV4_HDR_WORDS = IPV4_HDR_BYTES / 2;

  // eth_dst[0] / eth_src[0] are the first bytes on the wire
  typedef struct packed {
    logic [5:0][7:0] eth_dst;
    logic [5:0][7:0] eth_src;
    logic [15:0]     eth_type;
  } eth_hdr_struct;

  // Fields declared in wire order, so bit 159 is the first bit on the wire
  typedef struct packed {
    logic [3:0]  ip_v;
    logic [3:0]  ip_hl;
    logic [7:0]  ip_tos;
    logic [15:0] ip_len;
    logic [15:0] ip_id;
    logic [15:0] ip_off;
    logic [7:0]  ip_ttl;
    logic [7:0]  ip_p;
    logic [15:0] ip_sum;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
  } ipv4_hdr_struct;

  typedef struct packed {
    logic [15:0] th_sport;
    logic [15:0] th_dport;
    logic [31:0] th_seq;
    logic [31:0] th_ack;
    logic [3:0]  th_off;
    logic [3:0]  th_x2;
    logic [7:0]  th_flags;
    logic [15:0] th_win;
    logic [15:0] th_sum;
    logic [15:0] th_urp;
  } tcp_hdr_struct;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CSUM    = 2'd1,
    ST_HDR     = 2'd2,
    ST_PAYLOAD = 2'd3
  } tx_ser_state_e;

  // 16-bit header word k (0 = first on the wire) with the checksum field zeroed
  function automatic logic [15:0] ipv4_csum_word(input ipv4_hdr_struct h, input logic [3:0] k);
    ipv4_hdr_struct z;
    logic [159:0]   v;
    z        = h;
    z.ip_sum = '0;
    v        = z;
    v        = v >> (16 * (IPV4_HDR_WORDS - 1 - 32'(k)));
    return v[15:0];
  endfunction

endpackage

// File: rtl/tcp_pkt_serializer_csum.sv
// IPv4 header checksum accumulator: clear, add one 16-bit word per cycle,
// folded and inverted ones-complement result.
// Ports: clk, rst (sync, active-high), clr, add, word[15:0] -> csum_c[15:0].
module ipv4_csum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] csum_c
);

  logic [19:0] acc;
  logic [19:0] fold1;
  logic [15:0] fold2;

  // 20 bits hold the sum of ten 16-bit words without overflow
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + 20'(word);
    end
  end

  // Two folds always suffice: after the first the carry is at most 1
  always_comb begin
    fold1  = 20'(acc[15:0]) + 20'(acc[19:16]);
    fold2  = fold1[15:0] + 16'(fold1[19:16]);
    csum_c = ~fold2;
  end

endmodule

// File: rtl/tcp_pkt_serializer.sv
// Transmit serializer: takes one Ethernet/IPv4/TCP header set, emits the
// 54 header bytes in network order on an 8-bit stream, then passes the TCP
// payload through. Optional IPv4 checksum generation via `IPV4_CSUM_GEN_EN.
// Ports: clk, rst (sync, active-high); header handshake hdr_valid/hdr_ready
// with eth_hdr/ip_hdr/tcp_hdr; payload pl_data/pl_valid/pl_ready/pl_last;
// output stream out_data/out_valid/out_ready/out_sop/out_eop; len_err pulse.
module tcp_pkt_serializer
  import tcp_pkt_serializer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           hdr_valid,
  output logic           hdr_ready,
  input  eth_hdr_struct  eth_hdr,
  input  ipv4_hdr_struct ip_hdr,
  input  tcp_hdr_struct  tcp_hdr,
  input  logic [7:0]     pl_data,
  input  logic           pl_valid,
  output logic           pl_ready,
  input  logic           pl_last,
  output logic [7:0]     out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sop,
  output logic           out_eop,
  output logic           len_err
);

  localparam logic [15:0] MIN_IP_LEN = 16'(IPV4_HDR_BYTES + TCP_HDR_BYTES);
  localparam logic [5:0]  LAST_IDX   = 6'(TX_HDR_BYTES - 1);

  tx_ser_state_e  state;
  eth_hdr_struct  eth_r;
  ipv4_hdr_struct ip_r;
  tcp_hdr_struct  tcp_r;
  logic [5:0]     byte_idx;
  logic [15:0]    pl_cnt;      // payload length, then bytes still to forward
  logic           hdr_take;

  ipv4_hdr_struct ip_tx;
  logic [159:0]   ip_bits;
  logic [159:0]   tcp_bits;
  logic [7:0]     hdr_bytes [TX_HDR_BYTES];

  assign hdr_take = (state == ST_IDLE) && hdr_valid && hdr_ready;

`ifdef IPV4_CSUM_GEN_EN
  logic [3:0]  csum_idx;
  logic [15:0] csum_c;

  ipv4_csum_acc u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr    (hdr_take),
    .add    (state == ST_CSUM),
    .word   (ipv4_csum_word(ip_r, csum_idx)),
    .csum_c (csum_c)
  );
`endif

  // Header byte image built from the registered structs
  always_comb begin
    ip_tx = ip_r;
`ifdef IPV4_CSUM_GEN_EN
    ip_tx.ip_sum = csum_c;
`endif
    ip_bits  = ip_tx;
    tcp_bits = tcp_r;
    for (int i = 0; i < 6; i++) begin
      hdr_bytes[i]     = eth_r.eth_dst[i];
      hdr_bytes[6 + i] = eth_r.eth_src[i];
    end
    hdr_bytes[12] = eth_r.eth_type[15:8];
    hdr_bytes[13] = eth_r.eth_type[7:0];
    for (int i = 0; i < 20; i++) begin
      hdr_bytes[14 + i] = ip_bits[159 - 8 * i -: 8];
      hdr_bytes[34 + i] = tcp_bits[159 - 8 * i -: 8];
    end
  end

  // Output stream mux: header from registers, payload passed through
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    pl_ready  = 1'b0;
    case (state)
      ST_HDR: begin
        out_data  = hdr_bytes[byte_idx];
        out_valid = 1'b1;
        out_sop   = (byte_idx == '0);
        out_eop   = (byte_idx == LAST_IDX) && (pl_cnt == '0);
      end
      ST_PAYLOAD: begin
        out_data  = pl_data;
        out_valid = pl_valid;
        pl_ready  = out_ready;
        out_eop   = (pl_cnt == 16'd1);
      end
      default: ;
    endcase
  end

  // Control FSM with registered hdr_ready / len_err
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hdr_ready <= 1'b0;
      len_err   <= 1'b0;
      byte_idx  <= '0;
      pl_cnt    <= '0;
      eth_r     <= '0;
      ip_r      <= '0;
      tcp_r     <= '0;
`ifdef IPV4_CSUM_GEN_EN
      csum_idx  <= '0;
`endif
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hdr_take) begin
            eth_r     <= eth_hdr;
            ip_r      <= ip_hdr;
            tcp_r     <= tcp_hdr;
            hdr_ready <= 1'b0;
            byte_idx  <= '0;
            if (ip_hdr.ip_len < MIN_IP_LEN) begin
              pl_cnt  <= '0;
              len_err <= 1'b1;
            end else begin
              pl_cnt  <= ip_hdr.ip_len - MIN_IP_LEN;
            end
`ifdef IPV4_CSUM_GEN_EN
            csum_idx  <= '0;
            state     <= ST_CSUM;
`else
            state     <= ST_HDR;
`endif
          end else begin
            hdr_ready <= 1'b1;
          end
        end
`ifdef IPV4_CSUM_GEN_EN
        ST_CSUM: begin
          csum_idx <= csum_idx + 4'd1;
          if (csum_idx == 4'(IPV4_HDR_WORDS - 1)) begin
            state <= ST_HDR;
          end
        end
`endif
        ST_HDR: begin
          if (out_ready) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              if (pl_cnt == '0) begin
                state     <= ST_IDLE;
                hdr_ready <= 1'b1;
              end else begin
                state     <= ST_PAYLOAD;
              end
            end else begin
              byte_idx <= byte_idx + 6'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pl_valid && out_ready) begin
            pl_cnt <= pl_cnt - 16'd1;
            // Source's last marker must coincide with the final counted byte
            if (pl_last != (pl_cnt == 16'd1)) begin
              len_err <= 1'b1;
            end
            if (pl_cnt == 16'd1) begin
              state     <= ST_IDLE;
              hdr_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_pkt_serializer.sv
// Directed bench for tcp_pkt_serializer: header-only, payload, stalled
// output, length errors and mid-frame reset. Works with and without
// IPV4_CSUM_GEN_EN.
module tb_tcp_pkt_serializer;
  import tcp_pkt_serializer_pkg::*;

`ifdef IPV4_CSUM_GEN_EN
  localparam int EXP_LAT = 11;
`else
  localparam int EXP_LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           hdr_valid;
  logic           hdr_ready;
  eth_hdr_struct  eth_hdr;
  ipv4_hdr_struct ip_hdr;
  tcp_hdr_struct  tcp_hdr;
  logic [7:0]     pl_data;
  logic           pl_valid;
  logic           pl_ready;
  logic           pl_last;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_sop;
  logic           out_eop;
  logic           len_err;

  always #5 clk = ~clk;

  tcp_pkt_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .hdr_valid (hdr_valid),
    .hdr_ready (hdr_ready),
    .eth_hdr   (eth_hdr),
    .ip_hdr    (ip_hdr),
    .tcp_hdr   (tcp_hdr),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_last   (pl_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .len_err   (len_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  eth_hdr_struct  eth_t;
  ipv4_hdr_struct ip_t;
  tcp_hdr_struct  tcp_t;
  logic [7:0]     exp_q [$];
  logic [7:0]     got_q [$];
  logic [7:0]     pl_q  [$];
  logic           last_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] gb(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  // Reference ones-complement checksum over the IPv4 header, sum field excluded
  function automatic logic [15:0] csum_model(input ipv4_hdr_struct h);
    logic [31:0] s;
    s = 32'({h.ip_v, h.ip_hl, h.ip_tos}) + 32'(h.ip_len) + 32'(h.ip_id) + 32'(h.ip_off)
      + 32'({h.ip_ttl, h.ip_p}) + 32'(h.ip_src[31:16]) + 32'(h.ip_src[15:0])
      + 32'(h.ip_dst[31:16]) + 32'(h.ip_dst[15:0]);
    while ((s >> 16) != 0) s = (s & 32'h0000_ffff) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic p8(input logic [7:0] b);   exp_q.push_back(b); endtask
  task automatic p16(input logic [15:0] w); p8(w[15:8]); p8(w[7:0]); endtask
  task automatic p32(input logic [31:0] w); p16(w[31:16]); p16(w[15:0]); endtask

  // Expected frame: header fields in network order followed by pl_q
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < 6; i++) p8(eth_t.eth_dst[i]);
    for (int i = 0; i < 6; i++) p8(eth_t.eth_src[i]);
    p16(eth_t.eth_type);
    p8({ip_t.ip_v, ip_t.ip_hl}); p8(ip_t.ip_tos); p16(ip_t.ip_len); p16(ip_t.ip_id);
    p16(ip_t.ip_off); p8(ip_t.ip_ttl); p8(ip_t.ip_p);
`ifdef IPV4_CSUM_GEN_EN
    p16(csum_model(ip_t));
`else
    p16(ip_t.ip_sum);
`endif
    p32(ip_t.ip_src); p32(ip_t.ip_dst);
    p16(tcp_t.th_sport); p16(tcp_t.th_dport); p32(tcp_t.th_seq); p32(tcp_t.th_ack);
    p8({tcp_t.th_off, tcp_t.th_x2}); p8(tcp_t.th_flags);
    p16(tcp_t.th_win); p16(tcp_t.th_sum); p16(tcp_t.th_urp);
    foreach (pl_q[i]) p8(pl_q[i]);
  endtask

  task automatic set_payload(input int n, input logic [7:0] b0, input int last_at);
    pl_q.delete();
    last_q.delete();
    for (int i = 0; i < n; i++) begin
      pl_q.push_back(8'(b0 + 8'(i)));
      last_q.push_back(i == last_at);
    end
  endtask

  // Send eth_t/ip_t/tcp_t plus pl_q, collect the frame and check it
  task automatic run_frame(input string nm, input bit rnd, input int abort_at, input int exp_lerr);
    int cyc, lat, sop_pos, sop_cnt, eop_pos, lerr;
    bit done, seen, prev_stall;
    logic [7:0] prev_data;
    cyc = 0; lat = 0; sop_pos = -1; sop_cnt = 0; eop_pos = -1; lerr = 0;
    done = 1'b0; seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
    got_q.delete();
    @(negedge clk);
    eth_hdr = eth_t; ip_hdr = ip_t; tcp_hdr = tcp_t; hdr_valid = 1'b1;
    #1;
    chk({nm, " hdr_ready"}, 32'(hdr_ready), 32'd1);
    @(posedge clk);
    #1 hdr_valid = 1'b0;
    while (!done && cyc < 400 && !(abort_at >= 0 && got_q.size() == abort_at)) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pl_q.size() > 0) begin
        pl_valid = 1'b1; pl_data = pl_q[0]; pl_last = last_q[0];
      end else begin
        pl_valid = 1'b0; pl_data = '0; pl_last = 1'b0;
      end
      #1;
      cyc++;
      if (len_err) lerr++;
      if (!seen && out_valid) begin seen = 1'b1; lat = cyc; end
      if (prev_stall) begin
        chk({nm, " stall_valid"}, 32'(out_valid), 32'd1);
        chk({nm, " stall_data"}, 32'(out_data), 32'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (out_sop) begin sop_cnt++; sop_pos = got_q.size(); end
        got_q.push_back(out_data);
        if (out_eop) begin eop_pos = got_q.size() - 1; done = 1'b1; end
      end
      if (pl_valid && pl_ready) begin
        void'(pl_q.pop_front());
        void'(last_q.pop_front());
      end
    end
    if (abort_at >= 0) begin
      chk({nm, " bytes_before_abort"}, 32'(got_q.size()), 32'(abort_at));
      return;
    end
    chk({nm, " eop_seen"}, 32'(done), 32'd1);
    chk({nm, " first_valid_lat"}, 32'(lat), 32'(EXP_LAT));
    chk({nm, " frame_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("%s byte%0d", nm, i), 32'(gb(i)), 32'(exp_q[i]));
    chk({nm, " sop_cnt"}, 32'(sop_cnt), 32'd1);
    chk({nm, " sop_pos"}, 32'(sop_pos), 32'd0);
    chk({nm, " eop_pos"}, 32'(eop_pos), 32'(exp_q.size() - 1));
    @(negedge clk);
    out_ready = 1'b1; pl_valid = 1'b0; pl_last = 1'b0;
    #1;
    if (len_err) lerr++;
    chk({nm, " hdr_ready_after_eop"}, 32'(hdr_ready), 32'd1);
    chk({nm, " idle_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " len_err_pulses"}, 32'(lerr), 32'(exp_lerr));
  endtask

  initial begin
    rst = 1'b1; hdr_valid = 1'b0; out_ready = 1'b1;
    pl_valid = 1'b0; pl_data = '0; pl_last = 1'b0;
    eth_hdr = '0; ip_hdr = '0; tcp_hdr = '0;

    for (int i = 0; i < 6; i++) begin
      eth_t.eth_dst[i] = 8'(8'h10 + 8'(i));
      eth_t.eth_src[i] = 8'(8'h20 + 8'(i));
    end
    eth_t.eth_type = 16'h0800;
    ip_t = '{ip_v: 4'h4, ip_hl: 4'h5, ip_tos: 8'h00, ip_len: 16'h0028, ip_id: 16'h1c46,
             ip_off: 16'h4000, ip_ttl: 8'h40, ip_p: 8'h06, ip_sum: 16'h1111,
             ip_src: 32'hac10_0a63, ip_dst: 32'hac10_0a0c};
    tcp_t = '{th_sport: 16'h1234, th_dport: 16'h0050, th_seq: 32'h0102_0304,
              th_ack: 32'ha0b0_c0d0, th_off: 4'h5, th_x2: 4'h0, th_flags: 8'h18,
              th_win: 16'hffff, th_sum: 16'hbeef, th_urp: 16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst hdr_ready", 32'(hdr_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst pl_ready", 32'(pl_ready), 32'd0);
    chk("rst len_err", 32'(len_err), 32'd0);
    chk("rst sop_eop", 32'({out_sop, out_eop}), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst hdr_ready", 32'(hdr_ready), 32'd1);

    // Header only, ip_len = 40
    set_payload(0, 8'h00, -1);
    build_exp();
    run_frame("hdr40", 1'b0, -1, 0);
    chk("hdr40 eth_dst0", 32'(gb(0)), 32'h10);
    chk("hdr40 eth_src0", 32'(gb(6)), 32'h20);
    chk("hdr40 eth_type", 32'({gb(12), gb(13)}), 32'h0800);
    chk("hdr40 byte14", 32'(gb(14)), 32'h45);
    chk("hdr40 ip_len", 32'({gb(16), gb(17)}), 32'h0028);
    chk("hdr40 tcp_off", 32'(gb(46)), 32'h50);

    // Reference header with 20 payload bytes; sum field hand-known
    ip_t.ip_len = 16'h003c;
    set_payload(20, 8'h01, 19);
    build_exp();
    run_frame("hdr60", 1'b0, -1, 0);
`ifdef IPV4_CSUM_GEN_EN
    chk("hdr60 ip_sum", 32'({gb(24), gb(25)}), 32'hb1e6);
`else
    chk("hdr60 ip_sum", 32'({gb(24), gb(25)}), 32'h1111);
`endif

    // 4-byte payload, last on final byte
    ip_t.ip_len = 16'd44;
    set_payload(4, 8'hde, 3);
    pl_q[1] = 8'had; pl_q[2] = 8'hbe; pl_q[3] = 8'hef;
    build_exp();
    run_frame("pl4", 1'b0, -1, 0);
    chk("pl4 last_byte", 32'(gb(57)), 32'hef);

    // Same frame with random output backpressure
    set_payload(4, 8'hde, 3);
    pl_q[1] = 8'had; pl_q[2] = 8'hbe; pl_q[3] = 8'hef;
    build_exp();
    run_frame("pl4_stall", 1'b1, -1, 0);

    // Early pl_last on the second byte: one error, all 4 bytes still sent
    set_payload(4, 8'hde, 3);
    pl_q[1] = 8'had; pl_q[2] = 8'hbe; pl_q[3] = 8'hef;
    last_q[1] = 1'b1;
    build_exp();
    run_frame("early_last", 1'b0, -1, 1);

    // ip_len below the header size: header only, error pulse
    ip_t.ip_len = 16'd20;
    set_payload(0, 8'h00, -1);
    build_exp();
    run_frame("short_len", 1'b0, -1, 1);

    // Reset while header byte 20 is presented, then a clean frame
    ip_t.ip_len = 16'd40;
    set_payload(0, 8'h00, -1);
    build_exp();
    run_frame("abort", 1'b0, 20, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort hdr_ready_in_rst", 32'(hdr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort hdr_ready", 32'(hdr_ready), 32'd1);
    chk("abort out_valid_idle", 32'(out_valid), 32'd0);
    run_frame("after_abort", 1'b0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
